matmul_composed_ctrl: RTL and testbench

MATMUL_COMPOSED_CTRL -- requirements
Module: matmul_composed_ctrl

---
 rtl/matmul_composed_pkg.sv | 19 +
 rtl/matmul_composed_ctrl_if.sv | 33 +++
 rtl/matmul_c_fifo.sv | 43 ++++
 rtl/matmul_composed_ctrl.sv | 157 +++++++++++++++
 tb/tb_matmul_composed_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_composed_pkg.sv
// Shared definitions for the composed matmul controller: FSM state encoding and default parameters.
package matmul_composed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_TILE_ROWS      = 2;
  localparam int DEF_TILE_COLS      = 2;
  localparam int DEF_BB_SIZE        = 16;
  localparam int DEF_DWIDTH         = 8;
  localparam int DEF_AWIDTH         = 10;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/matmul_composed_ctrl_if.sv
// Bundle of the controller's tile-facing and stream-facing signals; master drives the controller inputs.
interface matmul_composed_ctrl_if #(
  parameter int TILE_ROWS = 2,
  parameter int TILE_COLS = 2,
  parameter int BB_SIZE   = 16,
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 10
);
  logic                                  start_mat_mul;
  logic                                  tile_start;
  logic [TILE_ROWS*TILE_COLS-1:0]        tile_done;
  logic [TILE_ROWS*BB_SIZE*DWIDTH-1:0]   c_in_data;
  logic [TILE_ROWS*AWIDTH-1:0]           c_in_addr;
  logic [TILE_ROWS-1:0]                  c_in_valid;
  logic [BB_SIZE*DWIDTH-1:0]             c_out_data;
  logic [AWIDTH-1:0]                     c_out_addr;
  logic                                  c_out_valid;
  logic                                  c_out_ready;
  logic                                  done_mat_mul;
  logic                                  busy;
  logic [TILE_ROWS-1:0]                  overflow;
  logic                                  timeout;

  modport master (
    output start_mat_mul, tile_done, c_in_data, c_in_addr, c_in_valid, c_out_ready,
    input  tile_start, c_out_data, c_out_addr, c_out_valid, done_mat_mul, busy, overflow, timeout
  );

  modport slave (
    input  start_mat_mul, tile_done, c_in_data, c_in_addr, c_in_valid, c_out_ready,
    output tile_start, c_out_data, c_out_addr, c_out_valid, done_mat_mul, busy, overflow, timeout
  );
endinterface

// File: rtl/matmul_c_fifo.sv
// One output-channel buffer; a push into a full FIFO is dropped unless a pop frees a slot that cycle.
module matmul_c_fifo #(
  parameter int WIDTH = 138,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             drop
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  // Extra MSB on each pointer separates full from empty when the index bits match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && full && !rd_en;
  assign dout  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/matmul_composed_ctrl.sv
// Composed matmul controller: start/done sequencing over a tile grid plus round-robin merge of row outputs.
// Optional RUN watchdog enabled by defining MATMUL_TIMEOUT_EN.
module matmul_composed_ctrl
  import matmul_composed_pkg::*;
#(
  parameter int TILE_ROWS      = DEF_TILE_ROWS,
  parameter int TILE_COLS      = DEF_TILE_COLS,
  parameter int BB_SIZE        = DEF_BB_SIZE,
  parameter int DWIDTH         = DEF_DWIDTH,
  parameter int AWIDTH         = DEF_AWIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   clk,
  input logic                   resetn,
  matmul_composed_ctrl_if.slave bus
);
  localparam int TILES = TILE_ROWS * TILE_COLS;
  localparam int DW    = BB_SIZE * DWIDTH;
  localparam int WW    = AWIDTH + DW;
  localparam int PTRW  = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  state_e                          state, state_nxt;
  logic                            clear, tile_start_nxt, tile_start_q;
  logic [TILES-1:0]                done_q;
  logic [TILE_ROWS-1:0]            overflow_q;
  logic                            to_hit;

  logic [TILE_ROWS-1:0]            f_empty, f_full, f_pop, f_drop;
  logic [TILE_ROWS-1:0][WW-1:0]    f_dout;
  logic [PTRW-1:0]                 rr_ptr, grant_idx;
  logic                            grant_vld, load;
  logic                            out_valid;
  logic [WW-1:0]                   out_word;

  // ---------------- channel buffers ----------------
  for (genvar r = 0; r < TILE_ROWS; r++) begin : g_ch
    matmul_c_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (bus.c_in_valid[r]),
      .din    ({bus.c_in_addr[r*AWIDTH +: AWIDTH], bus.c_in_data[r*DW +: DW]}),
      .pop    (f_pop[r]),
      .dout   (f_dout[r]),
      .empty  (f_empty[r]),
      .full   (f_full[r]),
      .drop   (f_drop[r])
    );
  end

  // ---------------- round-robin arbiter ----------------
  assign load = !out_valid || bus.c_out_ready;

  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < TILE_ROWS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= TILE_ROWS) idx = idx - TILE_ROWS;
      if (!grant_vld && !f_empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTRW'(idx);
      end
    end
  end

  always_comb begin
    f_pop = '0;
    if (load && grant_vld) f_pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (load) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_word <= f_dout[grant_idx];
        rr_ptr   <= (grant_idx == PTRW'(TILE_ROWS - 1)) ? '0 : grant_idx + PTRW'(1);
      end
    end
  end

  assign bus.c_out_valid = out_valid;
  assign bus.c_out_addr  = out_word[WW-1 -: AWIDTH];
  assign bus.c_out_data  = out_word[DW-1:0];

  // ---------------- control FSM ----------------
  always_comb begin
    state_nxt      = state;
    clear          = 1'b0;
    tile_start_nxt = 1'b0;
    case (state)
      ST_IDLE: if (bus.start_mat_mul) begin
        clear          = 1'b1;
        tile_start_nxt = 1'b1;
        state_nxt      = ST_RUN;
      end
      // Same-cycle done arrivals count toward completion
      ST_RUN:   if ((&(done_q | bus.tile_done)) || to_hit) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((&f_empty) && !out_valid) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      tile_start_q <= 1'b0;
      done_q       <= '0;
      overflow_q   <= '0;
    end else begin
      state        <= state_nxt;
      tile_start_q <= tile_start_nxt;
      if (clear)                done_q <= '0;
      else if (state == ST_RUN) done_q <= done_q | bus.tile_done;
      overflow_q <= (clear ? '0 : overflow_q) | f_drop;
    end
  end

  assign bus.tile_start   = tile_start_q;
  assign bus.busy         = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.done_mat_mul = (state == ST_DONE);
  assign bus.overflow     = overflow_q;

`ifdef MATMUL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_q;

  assign to_hit = (state == ST_RUN) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else if (clear) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      if (state == ST_RUN) to_cnt <= to_cnt + 1'b1;
      if (to_hit) to_q <= 1'b1;
    end
  end

  assign bus.timeout = to_q;
`else
  assign to_hit      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_composed_ctrl.sv
// Self-checking bench for matmul_composed_ctrl: directed control/datapath scenarios plus a randomized
// merge test against a queue-level reference model.
module tb_matmul_composed_ctrl;
  localparam int TR    = 2;
  localparam int TC    = 2;
  localparam int BB    = 16;
  localparam int DWD   = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int TO    = 64;
  localparam int DW    = BB * DWD;
  localparam int WW    = AW + DW;

  typedef logic [WW-1:0] word_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  matmul_composed_ctrl_if #(.TILE_ROWS(TR), .TILE_COLS(TC), .BB_SIZE(BB), .DWIDTH(DWD), .AWIDTH(AW)) bus ();

  matmul_composed_ctrl #(
    .TILE_ROWS(TR), .TILE_COLS(TC), .BB_SIZE(BB), .DWIDTH(DWD), .AWIDTH(AW),
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clr_inputs();
    bus.start_mat_mul = 1'b0;
    bus.tile_done     = '0;
    bus.c_in_valid    = '0;
    bus.c_in_addr     = '0;
    bus.c_in_data     = '0;
  endtask

  task automatic push_in(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.c_in_valid[ch]        = 1'b1;
    bus.c_in_addr[ch*AW +: AW] = a;
    bus.c_in_data[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clr_inputs();
    bus.c_out_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_inputs();
    bus.c_out_ready = 1'b0;
    resetn = 1'b0;
    #1;
    checks++; if (bus.tile_start !== 1'b0) begin failures++; $display("FAIL reset_tile_start got=%b exp=0", bus.tile_start); end
    checks++; if (bus.c_out_valid !== 1'b0) begin failures++; $display("FAIL reset_c_out_valid got=%b exp=0", bus.c_out_valid); end
    checks++; if ({bus.c_out_addr, bus.c_out_data} !== '0) begin failures++; $display("FAIL reset_c_out_word got=%h exp=0", {bus.c_out_addr, bus.c_out_data}); end
    checks++; if (bus.done_mat_mul !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_mat_mul); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.overflow !== '0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Start in cycle 0; done bits 0..3 arrive in cycles 10,12,12,20; a stray start in cycle 15 must be ignored.
  task automatic test_ctrl_sequence();
    logic exp_ts, exp_busy, exp_done;
    do_reset();
    for (int cyc = 0; cyc <= 25; cyc++) begin
      exp_ts   = (cyc == 1);
      exp_busy = (cyc >= 1) && (cyc <= 21);
      exp_done = (cyc == 22);
      checks++; if (bus.tile_start !== exp_ts) begin failures++; $display("FAIL ctrl_tile_start cyc=%0d got=%b exp=%b", cyc, bus.tile_start, exp_ts); end
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL ctrl_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
      checks++; if (bus.done_mat_mul !== exp_done) begin failures++; $display("FAIL ctrl_done cyc=%0d got=%b exp=%b", cyc, bus.done_mat_mul, exp_done); end
      clr_inputs();
      bus.start_mat_mul = (cyc == 0) || (cyc == 15);
      if (cyc == 10) bus.tile_done[0] = 1'b1;
      if (cyc == 12) bus.tile_done[2:1] = 2'b11;
      if (cyc == 20) bus.tile_done[3] = 1'b1;
      @(negedge clk);
    end
    clr_inputs();
  endtask

  // Half the tiles finish, a start pulse lands in RUN, then the rest finish: sticky bits must survive.
  task automatic test_start_ignored();
    logic exp_busy, exp_done, exp_ts;
    do_reset();
    for (int cyc = 0; cyc <= 13; cyc++) begin
      exp_ts   = (cyc == 1);
      exp_busy = (cyc >= 1) && (cyc <= 9);
      exp_done = (cyc == 10);
      checks++; if (bus.tile_start !== exp_ts) begin failures++; $display("FAIL ign_tile_start cyc=%0d got=%b exp=%b", cyc, bus.tile_start, exp_ts); end
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL ign_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
      checks++; if (bus.done_mat_mul !== exp_done) begin failures++; $display("FAIL ign_done cyc=%0d got=%b exp=%b", cyc, bus.done_mat_mul, exp_done); end
      clr_inputs();
      bus.start_mat_mul = (cyc == 0) || (cyc == 6);
      if (cyc == 5) bus.tile_done[1:0] = 2'b11;
      if (cyc == 8) bus.tile_done[3:2] = 2'b11;
      @(negedge clk);
    end
    clr_inputs();
  endtask

  task automatic test_merge();
    logic [DW-1:0] d0, d1;
    do_reset();
    bus.c_out_ready = 1'b1;
    d0 = rand_data();
    d1 = rand_data();
    push_in(0, 10'h010, d0);
    push_in(1, 10'h020, d1);
    @(negedge clk);
    clr_inputs();
    checks++; if (bus.c_out_valid !== 1'b0) begin failures++; $display("FAIL merge_t1_valid got=%b exp=0", bus.c_out_valid); end
    @(negedge clk);
    checks++; if (bus.c_out_valid !== 1'b1 || bus.c_out_addr !== 10'h010 || bus.c_out_data !== d0) begin
      failures++; $display("FAIL merge_first got=%b/%h/%h exp=1/010/%h", bus.c_out_valid, bus.c_out_addr, bus.c_out_data, d0); end
    @(negedge clk);
    checks++; if (bus.c_out_valid !== 1'b1 || bus.c_out_addr !== 10'h020 || bus.c_out_data !== d1) begin
      failures++; $display("FAIL merge_second got=%b/%h/%h exp=1/020/%h", bus.c_out_valid, bus.c_out_addr, bus.c_out_data, d1); end
    @(negedge clk);
    checks++; if (bus.c_out_valid !== 1'b0) begin failures++; $display("FAIL merge_t4_valid got=%b exp=0", bus.c_out_valid); end
  endtask

  // One word parks in the output register, four fill the FIFO, the sixth push is dropped.
  task automatic test_overflow();
    word_t sent [6];
    word_t got [$];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sent[k] = {AW'(10'h040 + k), rand_data()};
      clr_inputs();
      push_in(0, sent[k][WW-1 -: AW], sent[k][DW-1:0]);
      @(negedge clk);
    end
    clr_inputs();
    checks++; if (bus.overflow !== 2'b01) begin failures++; $display("FAIL ovf_flag got=%b exp=01", bus.overflow); end
    checks++; if (bus.c_out_valid !== 1'b1 || {bus.c_out_addr, bus.c_out_data} !== sent[0]) begin
      failures++; $display("FAIL ovf_held got=%b/%h exp=1/%h", bus.c_out_valid, bus.c_out_addr, sent[0][WW-1 -: AW]); end
    bus.c_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.c_out_valid === 1'b1) got.push_back({bus.c_out_addr, bus.c_out_data});
      @(negedge clk);
    end
    checks++; if (got.size() != 5) begin failures++; $display("FAIL ovf_count got=%0d exp=5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++; if (got[k] !== sent[k]) begin failures++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", k, got[k][WW-1 -: AW], sent[k][WW-1 -: AW]); end
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    for (int cyc = 0; cyc < 4; cyc++) begin
      clr_inputs();
      if (cyc == 0) bus.start_mat_mul = 1'b1;
      if (cyc == 1) begin push_in(0, 10'h101, rand_data()); push_in(1, 10'h102, rand_data()); end
      if (cyc == 2) push_in(0, 10'h103, rand_data());
      if (cyc == 3) bus.tile_done = '1;
      @(negedge clk);
    end
    clr_inputs();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.c_out_valid !== 1'b1) begin
      failures++; $display("FAIL drain_pre busy=%b valid=%b exp=1/1", bus.busy, bus.c_out_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if ({bus.tile_start, bus.c_out_valid, bus.done_mat_mul, bus.busy, bus.overflow, bus.timeout} !== '0 ||
                  {bus.c_out_addr, bus.c_out_data} !== '0) begin
      failures++; $display("FAIL drain_async_reset got=%b exp=0", {bus.tile_start, bus.c_out_valid, bus.done_mat_mul, bus.busy, bus.overflow, bus.timeout}); end
    @(negedge clk);
    resetn = 1'b1;
    bus.c_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (bus.c_out_valid !== 1'b0 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL drain_after_reset cyc=%0d valid=%b busy=%b exp=0/0", k, bus.c_out_valid, bus.busy); end
    end
  endtask

  task automatic test_timeout();
    logic exp_busy, exp_to, exp_done;
    do_reset();
`ifdef MATMUL_TIMEOUT_EN
    for (int cyc = 0; cyc <= 70; cyc++) begin
      exp_busy = (cyc >= 1) && (cyc <= TO + 1);
      exp_to   = (cyc >= TO + 1) && (cyc <= 69);
      exp_done = (cyc == TO + 2);
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL to_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
      checks++; if (bus.timeout !== exp_to) begin failures++; $display("FAIL to_flag cyc=%0d got=%b exp=%b", cyc, bus.timeout, exp_to); end
      checks++; if (bus.done_mat_mul !== exp_done) begin failures++; $display("FAIL to_done cyc=%0d got=%b exp=%b", cyc, bus.done_mat_mul, exp_done); end
      clr_inputs();
      bus.start_mat_mul = (cyc == 0) || (cyc == 69);
      if (cyc == 3) bus.tile_done[2:0] = 3'b111;
      @(negedge clk);
    end
`else
    for (int cyc = 0; cyc <= 100; cyc++) begin
      exp_busy = (cyc >= 1);
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL noto_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_busy); end
      checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL noto_flag cyc=%0d got=%b exp=0", cyc, bus.timeout); end
      clr_inputs();
      bus.start_mat_mul = (cyc == 0);
      if (cyc == 3) bus.tile_done[2:0] = 3'b111;
      @(negedge clk);
    end
`endif
    clr_inputs();
  endtask

  // Reference: per-channel queues, an output slot, a round-robin pointer, sticky overflow flags.
  task automatic test_random_merge();
    word_t      mq [TR][$];
    logic       m_ov;
    word_t      m_out;
    int         m_ptr;
    logic [TR-1:0] m_ovf;
    int         popped;
    do_reset();
    m_ov = 1'b0; m_out = '0; m_ptr = 0; m_ovf = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (bus.c_out_valid !== m_ov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, bus.c_out_valid, m_ov); end
      if (m_ov) begin
        checks++; if ({bus.c_out_addr, bus.c_out_data} !== m_out) begin
          failures++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", cyc, bus.c_out_addr, m_out[WW-1 -: AW]); end
      end
      checks++; if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", cyc, bus.overflow, m_ovf); end

      clr_inputs();
      bus.c_out_ready = (cyc > 360) ? 1'b1 : ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < TR; ch++)
        if (cyc < 340 && $urandom_range(0, 2) == 0) push_in(ch, AW'($urandom_range(0, 1023)), rand_data());

      popped = -1;
      if (!m_ov || bus.c_out_ready) begin
        m_ov = 1'b0;
        for (int i = 0; i < TR; i++) begin
          int c;
          c = (m_ptr + i) % TR;
          if (popped < 0 && mq[c].size() > 0) begin
            m_out  = mq[c].pop_front();
            m_ov   = 1'b1;
            m_ptr  = (c + 1) % TR;
            popped = c;
          end
        end
      end
      for (int ch = 0; ch < TR; ch++) begin
        if (bus.c_in_valid[ch]) begin
          if (mq[ch].size() < DEPTH) mq[ch].push_back({bus.c_in_addr[ch*AW +: AW], bus.c_in_data[ch*DW +: DW]});
          else m_ovf[ch] = 1'b1;
        end
      end
      @(negedge clk);
    end
    clr_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    clr_inputs();
    bus.c_out_ready = 1'b0;
    test_reset();
    test_ctrl_sequence();
    test_start_ignored();
    test_merge();
    test_overflow();
    test_reset_in_drain();
    test_timeout();
    test_random_merge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
